// File: rtl/regfile_param.sv
// Parameterised register file with a pending-write scoreboard, same-cycle write forwarding
// and a one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [WIDTH-1:0] rOut1,
  output logic [WIDTH-1:0] rOut2,
  input  logic [AW-1:0]    rd,
  input  logic             wr,
  input  logic [WIDTH-1:0] Din,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_rd,
  output logic             pend1,
  output logic             pend2,
  input  logic             clr,
  output logic             busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]    pend_q;

  logic we, rsv_set, fwd1, fwd2;

  // Writes and reservations to r0 are dropped so r0 and its pending bit stay zero.
  assign we      = wr && !busy && !(ZERO_R0 && (rd == '0));
  assign rsv_set = rsv && !busy && !(ZERO_R0 && (rsv_rd == '0));

  // Sweep FSM: state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep FSM: next state
  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (clr) state_d = StSweep;
      end
      StSweep: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sweep FSM: outputs
  always_comb begin
    busy = (state_q == StSweep);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (busy) begin
      mem_q[idx_q] <= '0;
    end else if (we) begin
      mem_q[rd] <= Din;
    end
  end

  // A reservation issued alongside a write to the same register wins (later assignment).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else if (busy) begin
      pend_q[idx_q] <= 1'b0;
    end else begin
      if (we)      pend_q[rd]     <= 1'b0;
      if (rsv_set) pend_q[rsv_rd] <= 1'b1;
    end
  end

  always_comb begin
    fwd1  = BYPASS && we && (rd == rs1);
    fwd2  = BYPASS && we && (rd == rs2);
    rOut1 = (ZERO_R0 && (rs1 == '0)) ? '0 : (fwd1 ? Din : mem_q[rs1]);
    rOut2 = (ZERO_R0 && (rs2 == '0)) ? '0 : (fwd2 ? Din : mem_q[rs2]);
    pend1 = fwd1 ? 1'b0 : pend_q[rs1];
    pend2 = fwd2 ? 1'b0 : pend_q[rs2];
  end

endmodule
